// File: rtl/snax_simbacore_seq_pkg.sv
// Shared types for the SimbaCore layer sequencer: FSM states, descriptor field
// indices and the packed descriptor layout (field 0 in the least significant bits).
package snax_simbacore_seq_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned NUM_FIELDS = 6;

    localparam int unsigned MODE   = 0;
    localparam int unsigned SEQLEN = 1;
    localparam int unsigned DMODEL = 2;
    localparam int unsigned DTRANK = 3;
    localparam int unsigned DINNER = 4;
    localparam int unsigned DFINAL = 5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        RUN,
        ERROR
    } seq_state_e;

    // First member lands in the MSBs, so list the fields from DFINAL down to MODE.
    typedef struct packed {
        logic [REG_W-1:0] dfinal;
        logic [REG_W-1:0] dinner;
        logic [REG_W-1:0] dtrank;
        logic [REG_W-1:0] dmodel;
        logic [REG_W-1:0] seqlen;
        logic [REG_W-1:0] mode;
    } desc_t;

endpackage

// File: rtl/snax_simbacore_desc_fifo.sv
// Synchronous descriptor FIFO with flush and a registered head output that
// reads as zero while the FIFO is empty.
module snax_simbacore_desc_fifo #(
    parameter int unsigned Width = 192,
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   level_o,
    output logic [Width-1:0]             head_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [LvlW-1:0]  level_q;
    logic [Width-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign full_o     = (level_q == LvlW'(Depth));
    assign empty_o    = (level_q == '0);
    assign push_ok    = push_i && !full_o && !flush_i;
    assign pop_ok     = pop_i && !empty_o && !flush_i;
    assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);
    assign level_o    = level_q;
    assign head_o     = head_q;

    // Next head: the following entry on a pop, or the incoming word when it becomes the only entry.
    always_comb begin
        head_d = head_q;
        if (pop_ok) begin
            if (level_q > LvlW'(1)) begin
                head_d = mem_q[rd_ptr_nxt];
            end else if (push_ok) begin
                head_d = data_i;
            end else begin
                head_d = '0;
            end
        end else if (push_ok && empty_o) begin
            head_d = data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_nxt;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
            head_q <= head_d;
        end
    end

    // Storage needs no reset; entries are only observed after being written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/snax_simbacore_layer_sequencer.sv
// Queues Mamba layer descriptors from the CSR side and launches them one at a
// time on the SimbaCore config port, tracking completion, timeouts and aborts.
module snax_simbacore_layer_sequencer
    import snax_simbacore_seq_pkg::*;
#(
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned NumCfgRegs   = 6,
    parameter int unsigned QueueDepth   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumCfgRegs*RegDataWidth-1:0]   desc_i,
    input  logic                                 desc_valid_i,
    output logic                                 desc_ready_o,
    output logic [NumCfgRegs*RegDataWidth-1:0]   cfg_o,
    output logic                                 cfg_valid_o,
    input  logic                                 cfg_ready_i,
    input  logic                                 core_busy_i,
    input  logic [RegDataWidth-1:0]              timeout_cycles_i,
    input  logic                                 abort_i,
    input  logic                                 clr_cnt_i,
    output logic                                 seq_busy_o,
    output logic                                 layer_done_o,
    output logic [RegDataWidth-1:0]              done_cnt_o,
    output logic [$clog2(QueueDepth+1)-1:0]      queue_level_o,
    output logic                                 timeout_o
);
    localparam int unsigned DescW = NumCfgRegs * RegDataWidth;

    seq_state_e              state_q, state_d;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop, handshake, in_flight, wd_hit, layer_fin;
    logic [RegDataWidth-1:0] wd_q, done_cnt_q;
    logic                    timeout_q, layer_done_q;

    assign push      = desc_valid_i && !fifo_full && !abort_i;
    assign handshake = (state_q == ISSUE) && cfg_ready_i;
    assign pop       = handshake && !abort_i;
    assign in_flight = (state_q == WAIT_START) || (state_q == RUN);
    assign wd_hit    = in_flight && (timeout_cycles_i != '0) && (wd_q == timeout_cycles_i);
    assign layer_fin = (state_q == RUN) && !core_busy_i && !wd_hit && !abort_i;

    snax_simbacore_desc_fifo #(
        .Width (DescW),
        .Depth (QueueDepth)
    ) i_desc_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (desc_i),
        .pop_i   (pop),
        .flush_i (abort_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (queue_level_o),
        .head_o  (cfg_o)
    );

    // Next-state logic; abort overrides every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !timeout_q) state_d = ISSUE;
            end
            ISSUE: begin
                if (cfg_ready_i) state_d = WAIT_START;
            end
            WAIT_START: begin
                if (wd_hit)           state_d = ERROR;
                else if (core_busy_i) state_d = RUN;
            end
            RUN: begin
                if (wd_hit) begin
                    state_d = ERROR;
                end else if (!core_busy_i) begin
                    state_d = (!fifo_empty || push) ? ISSUE : IDLE;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            layer_done_q <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            layer_done_q <= layer_fin;

            // Watchdog restarts on each launch and saturates instead of wrapping.
            if (abort_i || handshake) begin
                wd_q <= '0;
            end else if (in_flight && (wd_q != '1)) begin
                wd_q <= wd_q + RegDataWidth'(1);
            end

            if (abort_i)     timeout_q <= 1'b0;
            else if (wd_hit) timeout_q <= 1'b1;

            if (clr_cnt_i)      done_cnt_q <= '0;
            else if (layer_fin) done_cnt_q <= done_cnt_q + RegDataWidth'(1);
        end
    end

    assign desc_ready_o = !fifo_full;
    assign cfg_valid_o  = (state_q == ISSUE);
    assign seq_busy_o   = (state_q != IDLE) || !fifo_empty;
    assign layer_done_o = layer_done_q;
    assign done_cnt_o   = done_cnt_q;
    assign timeout_o    = timeout_q;

endmodule

// File: doc/snax_simbacore_layer_sequencer.md
Name: snax_simbacore_layer_sequencer

Overview:
- Sits between the CSR manager and the SimbaCore config port.
- Buffers a queue of layer descriptors (mode, seqLen, dModel, dtRank, dInner, dFinal) and issues them to the core's valid/ready config port one at a time.
- Tracks the core busy flag to detect layer completion and back-to-back launch.
- Provides a completed-layer counter, a watchdog timeout and an abort/flush path, so software can chain Mamba layers without per-layer polling.

Parameters:
- RegDataWidth, 32, width of one config field and of the counters.
- NumCfgRegs, 6, fields per descriptor (mode, seqLen, dModel, dtRank, dInner, dFinal).
- QueueDepth, 4, descriptor FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- desc_i  in  NumCfgRegs*RegDataWidth  descriptor to enqueue; field k is at bits [k*RegDataWidth +: RegDataWidth].
- desc_valid_i  in  1  enqueue request.
- desc_ready_o  out  1  queue not full.
- cfg_o  out  NumCfgRegs*RegDataWidth  head descriptor to the core config bits.
- cfg_valid_o  out  1  config valid to the core.
- cfg_ready_i  in  1  config ready from the core.
- core_busy_i  in  1  core busy flag.
- timeout_cycles_i  in  RegDataWidth  watchdog limit; 0 disables the watchdog.
- abort_i  in  1  flush the queue, return to IDLE, clear the error.
- clr_cnt_i  in  1  clear done_cnt_o.
- seq_busy_o  out  1  state is not IDLE, or the queue is non-empty.
- layer_done_o  out  1  one-cycle pulse on each layer completion.
- done_cnt_o  out  RegDataWidth  completed-layer count, wraps at 2^RegDataWidth.
- queue_level_o  out  $clog2(QueueDepth+1)  number of valid entries.
- timeout_o  out  1  sticky watchdog error.

Behaviour:
- Reset values:
  - State is IDLE, the queue is empty and all counters are 0.
  - desc_ready_o=1; cfg_valid_o, layer_done_o, timeout_o and seq_busy_o are 0.
  - cfg_o=0 while the queue is empty.
- Enqueue:
  - Push when desc_valid_i and desc_ready_o; desc_ready_o = !full.
  - No bypass: a push into a full queue is refused even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full queue keeps the level unchanged.
- cfg_o always shows the queue head (registered FIFO output). cfg_valid_o = (state==ISSUE).
- State machine:
  - IDLE: when the queue is non-empty and timeout_o=0, go to ISSUE. A push at cycle t into an empty queue gives cfg_valid_o high at t+2.
  - ISSUE: hold cfg_valid_o and a stable cfg_o until cfg_ready_i. On the handshake, pop the head, clear the watchdog and go to WAIT_START.
  - WAIT_START: go to RUN when core_busy_i=1. This covers the core raising busy one or more cycles after accepting the config.
  - RUN: when core_busy_i=0, pulse layer_done_o for 1 cycle and increment done_cnt_o. Then go to ISSUE directly if the queue is non-empty after this cycle's push, otherwise to IDLE. Minimum gap from busy falling to the next cfg_valid_o is 1 cycle.
  - ERROR: entered from WAIT_START or RUN when the watchdog count equals timeout_cycles_i and timeout_cycles_i != 0.
    - Sets timeout_o.
    - The queue is frozen (pops stop, pushes still accepted while not full).
    - Leaves ERROR only on abort_i.
- Watchdog:
  - Counts cycles spent in WAIT_START plus RUN, starting at 0 on the issue handshake.
  - Saturates and does not wrap.
  - Compared against timeout_cycles_i as sampled live.
- abort_i has highest priority, in any state, and takes effect the next cycle:
  - Queue emptied; state IDLE; timeout_o and watchdog cleared.
  - done_cnt_o is unchanged, and any push in the same cycle is dropped.
  - An abort during ISSUE deasserts cfg_valid_o without a handshake. The core is not reset; software must ensure the core is idle.
- clr_cnt_i clears done_cnt_o. If it coincides with a completion, the result is 0 (the clear wins).
- Asserting reset mid-operation drops all state immediately, with no pulses emitted.

Decomposition:
- Package snax_simbacore_seq_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_START, RUN, ERROR};
  - field index constants MODE=0, SEQLEN=1, DMODEL=2, DTRANK=3, DINNER=4, DFINAL=5;
  - a packed descriptor struct.
- Sub-module snax_simbacore_desc_fifo: parameterised synchronous FIFO with push, pop, flush, full, empty, level and head outputs, and a registered head.

Test Plan:
- Single layer: push descriptor {1,64,128,8,256,128} at cycle 0, core ready immediately, busy high for 20 cycles. Expect cfg_valid_o at cycle 2 with the exact fields, one layer_done_o pulse, done_cnt_o=1, and return to IDLE.
- Back-to-back: push 4 descriptors with the core holding ready low 3 cycles per issue. Expect in-order issue, desc_ready_o=0 after the 4th push and after a refused 5th push, queue_level_o counting 4→0, and done_cnt_o=4.
- Delayed busy: busy rises 3 cycles after the handshake. Expect the FSM to remain in WAIT_START with no false layer_done_o.
- Timeout: timeout_cycles_i=10, busy stuck high. Expect timeout_o=1 after 10 cycles in WAIT_START/RUN, and the next queued descriptor not issued. abort_i then clears timeout_o, empties the queue, and leaves done_cnt_o unchanged.
- Abort in ISSUE while cfg_ready_i=0: expect cfg_valid_o low the next cycle, queue_level_o=0 and seq_busy_o=0.
- clr_cnt_i in the same cycle as a completion: expect done_cnt_o=0 and layer_done_o still pulsed.
